// File: rtl/flag_branch_unit_if.sv
// flag_branch_unit_if: EX flag, branch handshake and statistics bundle for flag_branch_unit
interface flag_branch_unit_if #(parameter int CNT_W = 16);
  logic             ex_valid;
  logic             ex_stall;
  logic [3:0]       ex_opcode;
  logic [2:0]       flags_from_alu;
  logic             br_valid;
  logic [2:0]       br_ccc;
  logic             br_ready;
  logic             br_flush;
  logic             br_done;
  logic             br_taken;
  logic [2:0]       flags_out;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  modport master (
    output ex_valid, ex_stall, ex_opcode, flags_from_alu, br_valid, br_ccc, br_flush,
    input  br_ready, br_done, br_taken, flags_out, branch_cnt, taken_cnt
  );
  modport slave (
    input  ex_valid, ex_stall, ex_opcode, flags_from_alu, br_valid, br_ccc, br_flush,
    output br_ready, br_done, br_taken, flags_out, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural {N,V,Z} flags, conditional-branch resolution and branch statistics
module flag_branch_unit #(
  parameter int         CNT_W    = 16,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input logic clk,
  input logic rst,
  flag_branch_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;
  state_t           state, next;
  logic [2:0]       flags, eff, ccc_q, eval_ccc;
  logic [CNT_W-1:0] bcnt, tcnt;
  logic             taken, load, t, commit, wr_all, wr_z, pend;
  function automatic logic cond(input logic [2:0] c, input logic [2:0] f);
    logic [7:0] tbl;
    tbl = {1'b1, f[1], f[2] | f[0], f[0] | (~f[0] & ~f[2]), f[2], ~f[0] & ~f[2], f[0], ~f[0]};
    return tbl[c];
  endfunction
  assign commit   = bus.ex_valid & ~bus.ex_stall;
  assign wr_all   = bus.ex_opcode == 4'b0000 || bus.ex_opcode == 4'b0001;
  assign wr_z     = bus.ex_opcode == 4'b0010 || bus.ex_opcode == 4'b0100 ||
                    bus.ex_opcode == 4'b0101 || bus.ex_opcode == 4'b0110;
  assign pend     = bus.ex_valid & bus.ex_stall & (wr_all | wr_z);
  // eff doubles as the next flag register value: it only differs from flags on a committing writer
  assign eff      = commit & wr_all ? bus.flags_from_alu :
                    commit & wr_z   ? {flags[2:1], bus.flags_from_alu[0]} : flags;
  assign eval_ccc = state == IDLE ? bus.br_ccc : ccc_q;
  assign t        = cond(eval_ccc, eff);
  // next state and resolve strobe; a squashed writer leaves eff equal to flags
  always_comb begin
    next = state;
    load = 1'b0;
    if (state == IDLE && bus.br_valid && !bus.br_flush) begin
      next = pend ? WAIT : RESOLVE;
      load = !pend;
    end else if (state == WAIT) begin
      next = bus.br_flush ? IDLE : (commit || !bus.ex_valid) ? RESOLVE : WAIT;
      load = !bus.br_flush && (commit || !bus.ex_valid);
    end else if (state == RESOLVE) begin
      next = IDLE;
    end
  end
  // state, flags, latched condition, result and counters (counted as the result is registered)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flags <= FLAG_RST;
      ccc_q <= 3'b000;
      taken <= 1'b0;
      bcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= next;
      flags <= eff;
      if (state == IDLE) ccc_q <= bus.br_ccc;
      if (load) begin
        taken <= t;
        bcnt  <= &bcnt ? bcnt : bcnt + 1'b1;
        if (t) tcnt <= &tcnt ? tcnt : tcnt + 1'b1;
      end
    end
  end
  assign bus.br_ready   = state == IDLE;
  assign bus.br_done    = state == RESOLVE;
  assign bus.br_taken   = taken;
  assign bus.flags_out  = flags;
  assign bus.branch_cnt = bcnt;
  assign bus.taken_cnt  = tcnt;
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed and random checks of flag_branch_unit against a behavioural model
module tb_flag_branch_unit;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  flag_branch_unit_if #(.CNT_W(W)) bus();
  flag_branch_unit #(.CNT_W(W), .FLAG_RST(3'b000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [2:0]   m_flags, w_ccc;
  logic         m_ready, m_done, m_taken, waiting;
  int           m_bc, m_tc;
  function automatic logic cond(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    {n, v, z} = f;
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  function automatic bit writes(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
  endfunction
  function automatic logic [2:0] merged(input logic [3:0] op, input logic [2:0] alu, input logic [2:0] f);
    if (op inside {4'd0, 4'd1}) return alu;
    if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) return {f[2:1], alu[0]};
    return f;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic idle_in();
    bus.ex_valid = 0; bus.ex_stall = 0; bus.ex_opcode = 4'hF; bus.flags_from_alu = 0;
    bus.br_valid = 0; bus.br_ccc = 0; bus.br_flush = 0;
  endtask
  task automatic step(input string tag);
    logic       commit, pend, resolve, tk;
    logic [2:0] eff;
    commit  = bus.ex_valid && !bus.ex_stall;
    eff     = commit ? merged(bus.ex_opcode, bus.flags_from_alu, m_flags) : m_flags;
    pend    = bus.ex_valid && bus.ex_stall && writes(bus.ex_opcode);
    resolve = 0;
    tk      = 0;
    if (rst) begin
      m_flags = 0; m_done = 0; m_taken = 0; waiting = 0; m_bc = 0; m_tc = 0; m_ready = 1;
    end else begin
      if (m_done) begin
      end else if (waiting) begin
        if (bus.br_flush) waiting = 0;
        else if (commit || !bus.ex_valid) begin resolve = 1; tk = cond(w_ccc, eff); waiting = 0; end
      end else if (bus.br_valid && !bus.br_flush) begin
        if (pend) begin waiting = 1; w_ccc = bus.br_ccc; end
        else begin resolve = 1; tk = cond(bus.br_ccc, eff); end
      end
      m_done = resolve;
      if (resolve) begin
        m_taken = tk;
        m_bc = m_bc < (1 << W) - 1 ? m_bc + 1 : m_bc;
        if (tk) m_tc = m_tc < (1 << W) - 1 ? m_tc + 1 : m_tc;
      end
      m_ready = !resolve && !waiting;
      m_flags = eff;
    end
    @(posedge clk);
    #1;
    chk({tag, ".flags"}, bus.flags_out, m_flags);
    chk({tag, ".ready"}, bus.br_ready, m_ready);
    chk({tag, ".done"}, bus.br_done, m_done);
    chk({tag, ".taken"}, bus.br_taken, m_taken);
    chk({tag, ".bcnt"}, bus.branch_cnt, m_bc);
    chk({tag, ".tcnt"}, bus.taken_cnt, m_tc);
  endtask
  task automatic branch(input logic [2:0] c, input string tag);
    bus.br_valid = 1; bus.br_ccc = c;
    step(tag);
    idle_in();
  endtask
  initial begin
    idle_in();
    rst = 1;
    step("rst0");
    step("rst1");
    rst = 0;
    chk("rst.flags", bus.flags_out, 0);
    chk("rst.ready", bus.br_ready, 1);
    chk("rst.done", bus.br_done, 0);
    chk("rst.bcnt", bus.branch_cnt, 0);
    chk("rst.tcnt", bus.taken_cnt, 0);
    bus.ex_valid = 1; bus.ex_opcode = 4'd0; bus.flags_from_alu = 3'b001;
    branch(3'b001, "byp");
    chk("byp.done", bus.br_done, 1);
    chk("byp.taken", bus.br_taken, 1);
    chk("byp.flags", bus.flags_out, 3'b001);
    chk("byp.bcnt", bus.branch_cnt, 1);
    chk("byp.tcnt", bus.taken_cnt, 1);
    step("byp.idle");
    bus.ex_valid = 1; bus.ex_opcode = 4'd0; bus.flags_from_alu = 3'b110;
    step("mask.load");
    bus.ex_opcode = 4'd2; bus.flags_from_alu = 3'b000;
    step("mask.xor");
    chk("mask.flags", bus.flags_out, 3'b110);
    idle_in();
    branch(3'b011, "mask.lt");
    chk("mask.lt_taken", bus.br_taken, 1);
    step("mask.gap");
    branch(3'b110, "mask.ovf");
    chk("mask.ovf_taken", bus.br_taken, 1);
    step("mask.gap2");
    bus.ex_valid = 1; bus.ex_stall = 1; bus.ex_opcode = 4'd1; bus.flags_from_alu = 3'b001;
    bus.br_valid = 1; bus.br_ccc = 3'b000;
    step("stall.acc");
    bus.br_valid = 0;
    step("stall.w1");
    step("stall.w2");
    chk("stall.ready", bus.br_ready, 0);
    chk("stall.nodone", bus.br_done, 0);
    bus.ex_stall = 0;
    step("stall.commit");
    chk("stall.done", bus.br_done, 1);
    chk("stall.taken", bus.br_taken, 0);
    idle_in();
    step("stall.idle");
    bus.ex_valid = 1; bus.ex_stall = 1; bus.ex_opcode = 4'd1;
    bus.br_valid = 1; bus.br_ccc = 3'b111;
    step("flush.acc");
    bus.br_valid = 0; bus.br_flush = 1;
    step("flush.do");
    chk("flush.ready", bus.br_ready, 1);
    chk("flush.nodone", bus.br_done, 0);
    chk("flush.bcnt", bus.branch_cnt, 4);
    idle_in();
    step("flush.after");
    chk("flush.nodone2", bus.br_done, 0);
    for (int i = 0; i < 18; i++) begin
      branch(3'b111, "sat");
      step("sat.gap");
    end
    chk("sat.bcnt", bus.branch_cnt, 15);
    chk("sat.tcnt", bus.taken_cnt, 15);
    for (int i = 0; i < 2000; i++) begin
      rst                = $urandom_range(0, 99) == 0;
      bus.ex_valid       = $urandom_range(0, 3) != 0;
      bus.ex_stall       = $urandom_range(0, 2) == 0;
      bus.ex_opcode      = 4'($urandom);
      bus.flags_from_alu = 3'($urandom);
      bus.br_valid       = $urandom_range(0, 1) == 1;
      bus.br_ccc         = 3'($urandom);
      bus.br_flush       = $urandom_range(0, 7) == 0;
      step("rand");
    end
    rst = 0;
    idle_in();
    step("end");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
